// File: rtl/serial_display_decoder.sv
// -----------------------------------------------------------------------------
// serial_display_decoder
//
// Captures frames from a shift-register style 7-segment display driver and,
// optionally, decodes each captured byte into a hex digit code.
//
// A frame is accepted only when exactly SHIFT_WIDTH bits arrive between two
// latch pulses. Any other bit count is rejected and the outputs hold their
// previous values.
//
// Optional feature: define SERIAL_DISPLAY_DECODE_EN to enable the 7-segment
// decode. Without it, o_digits is tied to all 4'hF and o_decode_err to 0.
//
// Ports:
//   o_serial_clk   in   shift clock from the display driver; rising-edge logic
//   i_reset_n      in   synchronous active-low reset
//   i_serial_data  in   serial frame data, MSB first
//   i_serial_latch in   end-of-frame marker; its data bit is not shifted
//   o_segments     out  last accepted frame (first received byte in the MSBs)
//   o_digits       out  decoded digit per byte; digit 0 is the last byte
//   o_frame_valid  out  one-cycle pulse after a frame is accepted
//   o_frame_err    out  one-cycle pulse after a frame is rejected
//   o_decode_err   out  high while any accepted byte is undecodable
// -----------------------------------------------------------------------------
module serial_display_decoder #(
    parameter int unsigned SHIFT_WIDTH = 48,
    parameter int unsigned DIGITS      = 6
) (
    input  logic                    o_serial_clk,
    input  logic                    i_reset_n,
    input  logic                    i_serial_data,
    input  logic                    i_serial_latch,
    output logic [SHIFT_WIDTH-1:0]  o_segments,
    output logic [4*DIGITS-1:0]     o_digits,
    output logic                    o_frame_valid,
    output logic                    o_frame_err,
    output logic                    o_decode_err
);

    localparam int unsigned CNT_W = $clog2(SHIFT_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FULL, OVER} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       count;
    logic [SHIFT_WIDTH-1:0] shift_reg;

`ifdef SERIAL_DISPLAY_DECODE_EN
    logic [4*DIGITS-1:0] digits_next;
    logic                decode_err_next;

    // Decimal point (bit 7) is dropped by the caller before decoding.
    function automatic logic [3:0] decode_seg(input logic [6:0] seg);
        logic [3:0] code;
        case (seg)
            7'h3F:   code = 4'h0;
            7'h06:   code = 4'h1;
            7'h5B:   code = 4'h2;
            7'h4F:   code = 4'h3;
            7'h66:   code = 4'h4;
            7'h6D:   code = 4'h5;
            7'h7D:   code = 4'h6;
            7'h07:   code = 4'h7;
            7'h7F:   code = 4'h8;
            7'h6F:   code = 4'h9;
            7'h00:   code = 4'hF;
            default: code = 4'hE;
        endcase
        return code;
    endfunction

    // E is only ever produced for an unrecognised pattern, so it doubles as
    // the error flag.
    always_comb begin
        digits_next     = '1;
        decode_err_next = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            digits_next[4*i +: 4] = decode_seg(shift_reg[8*i +: 7]);
            if (decode_seg(shift_reg[8*i +: 7]) == 4'hE) begin
                decode_err_next = 1'b1;
            end
        end
    end
`else
    assign o_digits     = '1;
    assign o_decode_err = 1'b0;
`endif

    always_ff @(posedge o_serial_clk) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            count         <= '0;
            shift_reg     <= '0;
            o_segments    <= '0;
            o_frame_valid <= 1'b0;
            o_frame_err   <= 1'b0;
`ifdef SERIAL_DISPLAY_DECODE_EN
            o_digits      <= '1;
            o_decode_err  <= 1'b0;
`endif
        end else begin
            o_frame_valid <= 1'b0;
            o_frame_err   <= 1'b0;
            if (i_serial_latch) begin
                if (state == FULL) begin
                    o_segments    <= shift_reg;
                    o_frame_valid <= 1'b1;
`ifdef SERIAL_DISPLAY_DECODE_EN
                    o_digits      <= digits_next;
                    o_decode_err  <= decode_err_next;
`endif
                end else begin
                    o_frame_err <= 1'b1;
                end
                state <= IDLE;
                count <= '0;
            end else begin
                shift_reg <= {shift_reg[SHIFT_WIDTH-2:0], i_serial_data};
                case (state)
                    IDLE, SHIFT: begin
                        count <= count + CNT_W'(1);
                        state <= (count == CNT_W'(SHIFT_WIDTH - 1)) ? FULL : SHIFT;
                    end
                    // Count stays saturated; any extra bit marks the frame too long.
                    FULL, OVER: state <= OVER;
                    default:    state <= IDLE;
                endcase
            end
        end
    end

endmodule
